// File: rtl/branch_predict_ctrl.sv
// ============================================================================
// Module   : branch_predict_ctrl
// Brief    : Fetch-stage 2-bit branch predictor: counter table, in-flight FIFO,
//            resolution/flush and post-reset table walk. Option: BP_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef strongly_NT
`define strongly_NT    2'b00
`endif
`ifndef slightly_NT
`define slightly_NT    2'b01
`endif

module branch_predict_ctrl #(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = 4,
    parameter int INFL_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic        if_is_branch,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_imm,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    output logic        stall_if,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        flush,
    output logic [31:0] redirect_pc
);

    localparam int PTR_W = (INFL_DEPTH > 1) ? $clog2(INFL_DEPTH) : 1;
    localparam logic [PTR_W:0]   c_full     = (PTR_W + 1)'(INFL_DEPTH);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(BHT_ENTRIES - 1);
    localparam logic [1:0]       c_slightly_taken = 2'b10;
    localparam logic [1:0]       c_strongly_taken = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_init_idx;
    logic [1:0]         r_bht [BHT_ENTRIES];

    logic [31:0]        r_fifo_pc  [INFL_DEPTH];
    logic [IDX_W-1:0]   r_fifo_idx [INFL_DEPTH];
    logic [31:0]        r_fifo_ppc [INFL_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_flush;
    logic [31:0]        r_redirect_pc;

    logic               w_run;
    logic               w_full;
    logic               w_empty;
    logic               w_branch;
    logic               w_push;
    logic               w_resolve;
    logic               w_mispred;
    logic [IDX_W-1:0]   w_lookup_idx;
    logic [IDX_W-1:0]   w_head_idx;
    logic [1:0]         w_head_ctr;
    logic [1:0]         w_upd_ctr;
    logic [1:0]         w_pred_ctr;
    logic [31:0]        w_actual_pc;

    assign w_run        = (r_state == ST_RUN);
    assign w_full       = (r_count == c_full);
    assign w_empty      = (r_count == '0);
    assign w_branch     = w_run && if_valid && if_is_branch;
    assign w_push       = w_branch && !w_full;
    assign w_resolve    = w_run && ex_valid && !w_empty;
    assign w_lookup_idx = if_pc[IDX_W+1:2];
    assign w_head_idx   = r_fifo_idx[r_rd_ptr];
    assign w_head_ctr   = r_bht[w_head_idx];
    assign w_actual_pc  = ex_taken ? ex_target : ex_pc + 32'd4;
    assign w_mispred    = w_resolve &&
                          ((r_fifo_ppc[r_rd_ptr] != w_actual_pc) || (r_fifo_pc[r_rd_ptr] != ex_pc));

    always_comb begin
        w_upd_ctr = w_head_ctr;
        if (ex_taken) begin
            if (w_head_ctr != c_strongly_taken) w_upd_ctr = w_head_ctr + 2'd1;
        end else begin
            if (w_head_ctr != `strongly_NT) w_upd_ctr = w_head_ctr - 2'd1;
        end
    end

`ifdef BP_BYPASS_EN
    // Same-cycle resolve of the looked-up entry forwards the new counter value
    assign w_pred_ctr = (w_resolve && (w_head_idx == w_lookup_idx)) ? w_upd_ctr
                                                                      : r_bht[w_lookup_idx];
`else
    assign w_pred_ctr = r_bht[w_lookup_idx];
`endif

    assign pred_taken  = w_branch && w_pred_ctr[1];
    assign pred_pc     = pred_taken ? if_pc + if_imm : if_pc + 32'd4;
    assign stall_if    = rst || !w_run || (w_branch && w_full);
    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_bht[r_init_idx] <= c_slightly_taken;
            end else if (w_resolve) begin
                r_bht[w_head_idx] <= w_upd_ctr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]  <= if_pc;
            r_fifo_idx[r_wr_ptr] <= w_lookup_idx;
            r_fifo_ppc[r_wr_ptr] <= pred_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_init_idx    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_flush       <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_flush <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc <= w_actual_pc;
            end
            case (r_state)
                ST_INIT: begin
                    r_init_idx <= r_init_idx + 1'b1;
                    if (r_init_idx == c_last_idx) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    // A mispredict drops every tracked entry, including this cycle's push
                    if (w_mispred) begin
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_count  <= '0;
                    end else begin
                        if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (w_resolve) r_rd_ptr <= r_rd_ptr + 1'b1;
                        if (w_push && !w_resolve)      r_count <= r_count + 1'b1;
                        else if (!w_push && w_resolve) r_count <= r_count - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
// ============================================================================
// Module   : tb_branch_predict_ctrl
// Brief    : Directed vector bench for branch_predict_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predict_ctrl;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic        if_is_branch;
    logic [31:0] if_pc;
    logic [31:0] if_imm;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        stall_if;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        flush;
    logic [31:0] redirect_pc;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic        fv;
        logic        fb;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        ev;
        logic [31:0] epc;
        logic        et;
        logic [31:0] etgt;
        logic        x_pt;
        logic [31:0] x_ppc;
        logic        x_stall;
        logic        x_flush;
        logic [31:0] x_redir;
    } vec_t;

    branch_predict_ctrl #(
        .BHT_ENTRIES (16),
        .IDX_W       (4),
        .INFL_DEPTH  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_is_branch (if_is_branch),
        .if_pc        (if_pc),
        .if_imm       (if_imm),
        .pred_taken   (pred_taken),
        .pred_pc      (pred_pc),
        .stall_if     (stall_if),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_taken     (ex_taken),
        .ex_target    (ex_target),
        .flush        (flush),
        .redirect_pc  (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic fv, input logic fb, input logic [31:0] pc,
                                input logic [31:0] imm, input logic ev, input logic [31:0] epc,
                                input logic et, input logic [31:0] etgt, input logic x_pt,
                                input logic [31:0] x_ppc, input logic x_stall,
                                input logic x_flush, input logic [31:0] x_redir);
        vec_t v;
        v.fv = fv;   v.fb = fb;   v.pc = pc;     v.imm = imm;
        v.ev = ev;   v.epc = epc; v.et = et;     v.etgt = etgt;
        v.x_pt = x_pt; v.x_ppc = x_ppc; v.x_stall = x_stall;
        v.x_flush = x_flush; v.x_redir = x_redir;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic zero_inputs();
        if_valid = 0; if_is_branch = 0; if_pc = 0; if_imm = 0;
        ex_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
    endtask

    // One cycle: drive, check mid-cycle, advance past the next rising edge
    task automatic apply(input vec_t v, input string nm);
        if_valid = v.fv; if_is_branch = v.fb; if_pc = v.pc; if_imm = v.imm;
        ex_valid = v.ev; ex_pc = v.epc; ex_taken = v.et; ex_target = v.etgt;
        #4;
        if (v.fv && !v.x_stall) begin
            chk({nm, ".pred_taken"}, 32'(pred_taken), 32'(v.x_pt));
            chk({nm, ".pred_pc"}, pred_pc, v.x_ppc);
        end
        chk({nm, ".stall_if"}, 32'(stall_if), 32'(v.x_stall));
        chk({nm, ".flush"}, 32'(flush), 32'(v.x_flush));
        if (v.x_flush) chk({nm, ".redirect_pc"}, redirect_pc, v.x_redir);
        @(posedge clk); #1;
    endtask

    // Called one step after the reset edge; returns inside cycle 17
    task automatic init_walk(input string nm);
        zero_inputs();
        for (int k = 1; k <= 17; k++) begin
            #4;
            chk($sformatf("%s.stall_c%0d", nm, k), 32'(stall_if), (k <= 16) ? 32'd1 : 32'd0);
            if (k == 1) begin
                chk({nm, ".flush_rst"}, 32'(flush), 32'd0);
                chk({nm, ".redirect_rst"}, redirect_pc, 32'd0);
            end
            if (k < 17) begin
                @(posedge clk); #1;
            end
        end
    endtask

    vec_t tbl [25];

    initial begin
        tbl[0]  = mk(1,1,32'h40,32'h20, 0,32'h0,0,32'h0,   1,32'h60,0,0,32'h0);
        tbl[1]  = mk(0,0,32'h100,32'h0, 1,32'h40,1,32'h60, 0,32'h104,0,0,32'h0);
        tbl[2]  = mk(1,0,32'h200,32'h8, 1,32'h40,0,32'h0,  0,32'h204,0,0,32'h0);
        tbl[3]  = mk(1,1,32'h40,32'h20, 0,32'h0,0,32'h0,   1,32'h60,0,0,32'h0);
        tbl[4]  = mk(0,0,32'h0,32'h0,   1,32'h40,0,32'h60, 0,32'h4,0,0,32'h0);
        tbl[5]  = mk(1,1,32'h40,32'h20, 0,32'h0,0,32'h0,   1,32'h60,0,1,32'h44);
        tbl[6]  = mk(1,0,32'h40,32'h20, 1,32'h40,0,32'h60, 0,32'h44,0,0,32'h0);
        tbl[7]  = mk(1,1,32'h40,32'h20, 1,32'h40,0,32'h60, 0,32'h44,0,1,32'h44);
        tbl[8]  = mk(0,0,32'h0,32'h0,   1,32'h40,0,32'h60, 0,32'h4,0,0,32'h0);
        tbl[9]  = mk(1,1,32'h40,32'h20, 0,32'h0,0,32'h0,   0,32'h44,0,0,32'h0);
        tbl[10] = mk(0,0,32'h0,32'h0,   1,32'h40,0,32'h60, 0,32'h4,0,0,32'h0);
        tbl[11] = mk(1,1,32'h40,32'h20, 0,32'h0,0,32'h0,   0,32'h44,0,0,32'h0);
        tbl[12] = mk(0,0,32'h0,32'h0,   1,32'h40,1,32'h60, 0,32'h4,0,0,32'h0);
        tbl[13] = mk(1,1,32'h40,32'h20, 0,32'h0,0,32'h0,   0,32'h44,0,1,32'h60);
        tbl[14] = mk(0,0,32'h0,32'h0,   1,32'h40,1,32'h60, 0,32'h4,0,0,32'h0);
        tbl[15] = mk(1,1,32'h40,32'h20, 0,32'h0,0,32'h0,   1,32'h60,0,1,32'h60);
        tbl[16] = mk(1,1,32'h44,32'h10, 0,32'h0,0,32'h0,   1,32'h54,0,0,32'h0);
        tbl[17] = mk(1,1,32'h48,32'h8,  0,32'h0,0,32'h0,   1,32'h50,1,0,32'h0);
        tbl[18] = mk(1,1,32'h48,32'h8,  1,32'h40,1,32'h60, 1,32'h50,1,0,32'h0);
        tbl[19] = mk(1,1,32'h48,32'h8,  1,32'h44,1,32'h54, 1,32'h50,0,0,32'h0);
        tbl[20] = mk(1,1,32'h4C,32'h4,  0,32'h0,0,32'h0,   1,32'h50,0,0,32'h0);
        tbl[21] = mk(1,1,32'h4C,32'h4,  0,32'h0,0,32'h0,   1,32'h50,1,0,32'h0);
        tbl[22] = mk(0,0,32'h0,32'h0,   1,32'h100,1,32'h50,0,32'h4,0,0,32'h0);
        tbl[23] = mk(0,0,32'h0,32'h0,   1,32'h4C,1,32'h50, 0,32'h4,0,1,32'h50);
        tbl[24] = mk(0,0,32'h0,32'h0,   0,32'h0,0,32'h0,   0,32'h4,0,0,32'h0);

        // Power-on reset and table walk
        zero_inputs();
        rst = 1'b1;
        #2;
        chk("reset.stall_if", 32'(stall_if), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        init_walk("init");

        for (int i = 0; i < 25; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Same-cycle lookup/update of index 5
        apply(mk(1,1,32'h54,32'h10, 0,32'h0,0,32'h0,   1,32'h64,0,0,32'h0), "b0");
        apply(mk(0,0,32'h0,32'h0,   1,32'h54,0,32'h64, 0,32'h4,0,0,32'h0),  "b1");
        apply(mk(1,1,32'h54,32'h10, 0,32'h0,0,32'h0,   0,32'h58,0,1,32'h58), "b2");
        apply(mk(0,0,32'h0,32'h0,   1,32'h54,0,32'h64, 0,32'h4,0,0,32'h0),  "b3");
        apply(mk(1,1,32'h54,32'h10, 0,32'h0,0,32'h0,   0,32'h58,0,0,32'h0), "b4");
        apply(mk(1,1,32'h54,32'h10, 1,32'h54,1,32'h64, 0,32'h58,0,0,32'h0), "b5");
        apply(mk(1,1,32'h54,32'h10, 0,32'h0,0,32'h0,   0,32'h58,0,1,32'h64), "b6");
`ifdef BP_BYPASS_EN
        apply(mk(1,1,32'h54,32'h10, 1,32'h54,1,32'h64, 1,32'h64,0,0,32'h0), "b7");
`else
        apply(mk(1,1,32'h54,32'h10, 1,32'h54,1,32'h64, 0,32'h58,0,0,32'h0), "b7");
`endif
        apply(mk(0,0,32'h0,32'h0,   0,32'h0,0,32'h0,   0,32'h4,0,1,32'h64),  "b8");
        apply(mk(1,1,32'h54,32'h10, 0,32'h0,0,32'h0,   1,32'h64,0,0,32'h0), "b9");

        // Reset with two entries in flight and a mispredict resolving
        apply(mk(1,1,32'h44,32'h10, 0,32'h0,0,32'h0,   1,32'h54,0,0,32'h0), "r0");
        rst = 1'b1;
        if_valid = 1; if_is_branch = 1; if_pc = 32'h48; if_imm = 32'h8;
        ex_valid = 1; ex_pc = 32'h54; ex_taken = 0; ex_target = 32'h64;
        #4;
        chk("r1.stall_if", 32'(stall_if), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        init_walk("rerun");
        apply(mk(0,0,32'h0,32'h0,   1,32'h54,0,32'h64, 0,32'h4,0,0,32'h0), "r2");
        apply(mk(0,0,32'h0,32'h0,   0,32'h0,0,32'h0,   0,32'h4,0,0,32'h0), "r3");
        for (int i = 0; i < 16; i++) begin
            apply(mk(1,1,32'(4*i),32'h100, 0,32'h0,0,32'h0, 1,32'(4*i+256),0,0,32'h0),
                  $sformatf("wt%0d", i));
            apply(mk(0,0,32'h0,32'h0, 1,32'(4*i),1,32'(4*i+256), 0,32'h4,0,0,32'h0),
                  $sformatf("wr%0d", i));
        end
        apply(mk(0,0,32'h0,32'h0, 0,32'h0,0,32'h0, 0,32'h4,0,0,32'h0), "end");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
